// File: rtl/imm_ctrl_pkg.sv
// Shared types and constants for the WISC decode-stage immediate controller.
// Optional feature macro: IMM_CTRL_ZEXT_EN (zero-extension for XORI/ANDNI/SLBI).
package imm_ctrl_pkg;

    localparam int unsigned DATA_W = 16;

    // Immediate format carried with each buffered instruction
    typedef enum logic [1:0] {
        FMT_I5   = 2'd0,
        FMT_I8   = 2'd1,
        FMT_J11  = 2'd2,
        FMT_NONE = 2'd3
    } fmt_t;

    // Skid-buffer occupancy; encoding equals the number of held entries
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_t;

    // Opcodes that need individual attention during decode
    localparam logic [4:0] OP_XORI  = 5'b01010;
    localparam logic [4:0] OP_ANDNI = 5'b01011;
    localparam logic [4:0] OP_SLBI  = 5'b10010;
    localparam logic [4:0] OP_LBI   = 5'b11000;

    // Instruction word presented on the outputs when nothing has been issued
    localparam logic [15:0] NOP_WORD = 16'h0800;

    // Classify a 5-bit opcode into its immediate format.
    // SLBI sits inside the 100xx memory group, so it is tested first.
    function automatic fmt_t classify(input logic [4:0] op);
        fmt_t f;
        if (op == OP_SLBI || op == OP_LBI ||
            op[4:2] == 3'b011 ||
            (op[4:2] == 3'b001 && op[0])) begin
            f = FMT_I8;
        end else if (op[4:2] == 3'b001) begin
            f = FMT_J11;
        end else if (op[4:2] == 3'b010 || op[4:2] == 3'b100 ||
                     op[4:2] == 3'b101) begin
            f = FMT_I5;
        end else begin
            f = FMT_NONE;
        end
        return f;
    endfunction

    // Logical-immediate opcodes whose field is an unsigned quantity
    function automatic logic is_zext_op(input logic [4:0] op);
        return (op == OP_XORI) || (op == OP_ANDNI) || (op == OP_SLBI);
    endfunction

endpackage

// File: rtl/imm_extend.sv
// Immediate extender: widens a 5/8/11-bit instruction field to 16 bits,
// sign-extending by default or zero-extending when zext is set.
module imm_extend
    import imm_ctrl_pkg::*;
(
    input  logic [10:0] field,
    input  fmt_t        fmt,
    input  logic        zext,
    output logic [15:0] imm
);

    // Select the field width by format, then fill the upper bits
    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I5:  imm = zext ? {11'b0, field[4:0]} : {{11{field[4]}}, field[4:0]};
            FMT_I8:  imm = zext ? {8'b0, field[7:0]}  : {{8{field[7]}}, field[7:0]};
            FMT_J11: imm = {{5{field[10]}}, field[10:0]};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/imm_issue_ctrl.sv
// Decode-stage immediate controller with a 2-entry skid buffer.
// Instructions are decoded and extended on push; the buffer stores the
// extended result so the issue path is purely registered.
// Build option: define IMM_CTRL_ZEXT_EN to zero-extend XORI/ANDNI/SLBI.
module imm_issue_ctrl
    import imm_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned DW    = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [DW-1:0] in_instr,
    output logic          in_ready,
    input  logic          flush,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_instr,
    output logic [DW-1:0] out_imm,
    output logic [1:0]    out_fmt
);

    localparam logic [1:0] FULL_OCC = 2'(DEPTH);

    occ_t          state;
    logic [4:0]    opcode;
    fmt_t          in_fmt;
    logic          in_zext;
    logic [DW-1:0] in_imm;
    logic          push;
    logic          pop;

    // Second (younger) entry, only meaningful in OCC_FULL
    logic [DW-1:0] skid_instr;
    logic [DW-1:0] skid_imm;
    logic [1:0]    skid_fmt;

    assign opcode = in_instr[15:11];
    assign in_fmt = classify(opcode);

`ifdef IMM_CTRL_ZEXT_EN
    assign in_zext = is_zext_op(opcode);
`else
    assign in_zext = 1'b0;
`endif

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    imm_extend u_ext (
        .field (in_instr[10:0]),
        .fmt   (in_fmt),
        .zext  (in_zext),
        .imm   (in_imm)
    );

    // Occupancy FSM; the head entry lives directly in the out_* registers
    // and in_ready/out_valid are registered alongside the state transition
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= OCC_EMPTY;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_instr  <= NOP_WORD;
            out_imm    <= '0;
            out_fmt    <= FMT_NONE;
            skid_instr <= NOP_WORD;
            skid_imm   <= '0;
            skid_fmt   <= FMT_NONE;
        end else if (flush) begin
            state     <= OCC_EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    in_ready <= 1'b1;
                    if (push) begin
                        out_instr <= in_instr;
                        out_imm   <= in_imm;
                        out_fmt   <= in_fmt;
                        out_valid <= 1'b1;
                        state     <= OCC_ONE;
                    end
                end
                OCC_ONE: begin
                    in_ready <= 1'b1;
                    case ({push, pop})
                        2'b10: begin
                            skid_instr <= in_instr;
                            skid_imm   <= in_imm;
                            skid_fmt   <= in_fmt;
                            in_ready   <= (2'd2 < FULL_OCC);
                            state      <= OCC_FULL;
                        end
                        2'b01: begin
                            out_valid <= 1'b0;
                            state     <= OCC_EMPTY;
                        end
                        2'b11: begin
                            out_instr <= in_instr;
                            out_imm   <= in_imm;
                            out_fmt   <= in_fmt;
                        end
                        default: ;
                    endcase
                end
                OCC_FULL: begin
                    if (pop) begin
                        out_instr <= skid_instr;
                        out_imm   <= skid_imm;
                        out_fmt   <= skid_fmt;
                        in_ready  <= 1'b1;
                        state     <= OCC_ONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= OCC_EMPTY;
                end
            endcase
        end
    end

endmodule
